// File: rtl/decap_packet_gen.sv
// DFX packet decapsulator: rebuilds one DATA_DFX_WIDTH-bit packet from a stream of
// AURORA_DATA_WIDTH-bit frames, checks frame headers and presents the result through a
// valid/ready holding register.
module decap_packet_gen #(
    parameter int unsigned DATA_WIDTH        = 1024,
    parameter int unsigned ADDR_WIDTH        = 10,
    parameter int unsigned DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int unsigned AURORA_DATA_WIDTH = 64,
    parameter int unsigned HDR_WIDTH         = 9,
    parameter int unsigned RD_LATENCY        = 1,
    localparam int unsigned SLICE_WIDTH      = AURORA_DATA_WIDTH - HDR_WIDTH,
    localparam int unsigned NUM_FRAMES       = (DATA_DFX_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH,
    localparam int unsigned LAST_BITS        = DATA_DFX_WIDTH - (NUM_FRAMES - 1) * SLICE_WIDTH,
    localparam int unsigned CNT_W            = $clog2(NUM_FRAMES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_en,
    input  logic [AURORA_DATA_WIDTH-1:0] data_in_dfx,
    input  logic                         out_ready,
    output logic                         decap_ready,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic                         valid_dfx_data,
    output logic                         done_decap_pkt,
    output logic                         err_seq,
    output logic                         err_len,
    output logic                         err_ovf,
    output logic [CNT_W-1:0]             frame_cnt
);

    localparam int unsigned SEQ_W = HDR_WIDTH - 2;

    typedef enum logic [0:0] {StIdle, StAssemble} state_t;

    state_t                   state;
    logic [RD_LATENCY-1:0]    rd_dly;
    logic [DATA_DFX_WIDTH-1:0] asm_buf;
    logic [DATA_DFX_WIDTH-1:0] pkt;

    logic                     fv;
    logic [SLICE_WIDTH-1:0]   slice;
    logic                     sof;
    logic                     eof;
    logic [SEQ_W-1:0]         seq;
    logic                     last_frame;
    logic [CNT_W-1:0]         wr_idx;
    int unsigned              inflight;

    logic do_start, do_append, do_complete, set_err_seq, set_err_len;

    assign fv         = rd_dly[RD_LATENCY-1];
    assign slice      = data_in_dfx[AURORA_DATA_WIDTH-1:HDR_WIDTH];
    assign sof        = data_in_dfx[HDR_WIDTH-1];
    assign eof        = data_in_dfx[HDR_WIDTH-2];
    assign seq        = data_in_dfx[SEQ_W-1:0];
    assign last_frame = (32'(frame_cnt) == NUM_FRAMES - 1);
    assign wr_idx     = do_start ? '0 : frame_cnt;

    // Read strobe delay line: its tail marks the cycle the frame is on data_in_dfx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dly <= '0;
        end else begin
            rd_dly[0] <= rd_en;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_dly[i] <= rd_dly[i-1];
            end
        end
    end

    // Header decode: exactly one action (or error) per valid frame, in priority order
    always_comb begin
        do_start    = 1'b0;
        do_append   = 1'b0;
        do_complete = 1'b0;
        set_err_seq = 1'b0;
        set_err_len = 1'b0;
        if (fv) begin
            if (state == StIdle || sof) begin
                // SOF inside a packet is itself a violation; the frame then restarts assembly
                if (state == StAssemble) set_err_seq = 1'b1;
                if (sof) begin
                    if (seq != '0) begin
                        set_err_seq = 1'b1;
                    end else if (NUM_FRAMES == 1) begin
                        if (eof) do_complete = 1'b1;
                        else     set_err_len = 1'b1;
                    end else begin
                        do_start = 1'b1;
                    end
                end
            end else if (32'(seq) != 32'(frame_cnt)) begin
                set_err_seq = 1'b1;
            end else if (last_frame != eof) begin
                set_err_len = 1'b1;
            end else if (!last_frame) begin
                do_append = 1'b1;
            end else begin
                do_complete = 1'b1;
            end
        end
    end

    // Completed packet: buffered slices plus the final slice straight from the current frame
    always_comb begin
        pkt = asm_buf;
        pkt[DATA_DFX_WIDTH-1 -: LAST_BITS] = slice[LAST_BITS-1:0];
    end

    // Reads still in the delay line that will land on frame_cnt
    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 32'(rd_dly[i]);
        end
    end

    assign decap_ready = !valid_dfx_data || out_ready ||
                         (32'(frame_cnt) + inflight < NUM_FRAMES - 1);

    // Assembly FSM, buffer, output holding register and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            frame_cnt      <= '0;
            asm_buf        <= '0;
            data_dfx_recv  <= '0;
            valid_dfx_data <= 1'b0;
            done_decap_pkt <= 1'b0;
            err_seq        <= 1'b0;
            err_len        <= 1'b0;
            err_ovf        <= 1'b0;
        end else begin
            done_decap_pkt <= 1'b0;
            err_ovf        <= 1'b0;
            err_seq        <= set_err_seq;
            err_len        <= set_err_len;

            if (valid_dfx_data && out_ready) valid_dfx_data <= 1'b0;

            if (do_start || do_append) begin
                for (int unsigned k = 0; k < NUM_FRAMES - 1; k++) begin
                    if (32'(wr_idx) == k) asm_buf[k*SLICE_WIDTH +: SLICE_WIDTH] <= slice;
                end
                frame_cnt <= do_start ? CNT_W'(1) : frame_cnt + 1'b1;
                state     <= StAssemble;
            end else if (do_complete) begin
                frame_cnt <= '0;
                state     <= StIdle;
                // A held, unaccepted packet wins; the new one is dropped and flagged
                if (!valid_dfx_data || out_ready) begin
                    data_dfx_recv  <= pkt;
                    valid_dfx_data <= 1'b1;
                    done_decap_pkt <= 1'b1;
                end else begin
                    err_ovf <= 1'b1;
                end
            end else if (set_err_seq || set_err_len) begin
                frame_cnt <= '0;
                state     <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_decap_packet_gen.sv
// Directed bench for decap_packet_gen: default build (64-bit frames, latency 1) plus a
// 128-bit-frame / latency-3 build, both fed from one clock.
module tb_decap_packet_gen;

    localparam int DW   = 1034;
    localparam int SW0  = 64 - 9;
    localparam int NF0  = (DW + SW0 - 1) / SW0;
    localparam int LB0  = DW - (NF0 - 1) * SW0;
    localparam int SW1  = 128 - 9;
    localparam int NF1  = (DW + SW1 - 1) / SW1;
    localparam int LB1  = DW - (NF1 - 1) * SW1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          rd_en0, out_ready0, decap_ready0, valid0, done0, eseq0, elen0, eovf0;
    logic [63:0]   data_in0;
    logic [DW-1:0] recv0;
    logic [4:0]    fcnt0;
    logic          rd_en1, out_ready1, decap_ready1, valid1, done1, eseq1, elen1, eovf1;
    logic [127:0]  data_in1;
    logic [DW-1:0] recv1;
    logic [3:0]    fcnt1;

    decap_packet_gen dut0 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en0), .data_in_dfx(data_in0),
        .out_ready(out_ready0), .decap_ready(decap_ready0), .data_dfx_recv(recv0),
        .valid_dfx_data(valid0), .done_decap_pkt(done0), .err_seq(eseq0), .err_len(elen0),
        .err_ovf(eovf0), .frame_cnt(fcnt0)
    );

    decap_packet_gen #(.AURORA_DATA_WIDTH(128), .RD_LATENCY(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en1), .data_in_dfx(data_in1),
        .out_ready(out_ready1), .decap_ready(decap_ready1), .data_dfx_recv(recv1),
        .valid_dfx_data(valid1), .done_decap_pkt(done1), .err_seq(eseq1), .err_len(elen1),
        .err_ovf(eovf1), .frame_cnt(fcnt1)
    );

    int checks = 0;
    int errors = 0;
    int cd0, cs0, cl0, co0, cd1, cs1, cl1, co1;
    logic [DW-1:0]  last0, last1;
    logic [63:0]    fq0;
    logic [127:0]   fq1 [LAT1];

    typedef struct {
        string name;
        int    n;
        int    restart;
        int    eof_pos;
        int    bad_pos;
        int    bad_val;
        int    tag;
        int    e_done;
        int    e_seq;
        int    e_len;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [SW0-1:0] sl0(input int tag, input int k);
        logic [SW0-1:0] s;
        s = SW0'(k + 1) | (SW0'(tag) << 40);
        return s;
    endfunction

    function automatic logic [SW1-1:0] sl1(input int tag, input int k);
        logic [SW1-1:0] s;
        s = SW1'(k + 1) | (SW1'(tag) << 100);
        return s;
    endfunction

    function automatic logic [DW-1:0] exp0(input int tag);
        logic [DW-1:0]  e;
        logic [SW0-1:0] s;
        e = '0;
        for (int k = 0; k < NF0 - 1; k++) e[k*SW0 +: SW0] = sl0(tag, k);
        s = sl0(tag, NF0 - 1);
        e[DW-1 -: LB0] = s[LB0-1:0];
        return e;
    endfunction

    function automatic logic [DW-1:0] exp1(input int tag);
        logic [DW-1:0]  e;
        logic [SW1-1:0] s;
        e = '0;
        for (int k = 0; k < NF1 - 1; k++) e[k*SW1 +: SW1] = sl1(tag, k);
        s = sl1(tag, NF1 - 1);
        e[DW-1 -: LB1] = s[LB1-1:0];
        return e;
    endfunction

    // One clock: frames requested via rd appear on data_in after each DUT's latency
    task automatic cycle(input logic r0, input logic [63:0] f0,
                         input logic r1, input logic [127:0] f1);
        data_in0 = fq0;
        fq0      = f0;
        rd_en0   = r0;
        data_in1 = fq1[LAT1-1];
        for (int i = LAT1 - 1; i > 0; i--) fq1[i] = fq1[i-1];
        fq1[0]   = f1;
        rd_en1   = r1;
        @(posedge clk);
        #1;
        cd0 += int'(done0); cs0 += int'(eseq0); cl0 += int'(elen0); co0 += int'(eovf0);
        cd1 += int'(done1); cs1 += int'(eseq1); cl1 += int'(elen1); co1 += int'(eovf1);
        if (done0) last0 = recv0;
        if (done1) last1 = recv1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, '0);
    endtask

    task automatic clr();
        cd0 = 0; cs0 = 0; cl0 = 0; co0 = 0; cd1 = 0; cs1 = 0; cl1 = 0; co1 = 0;
        last0 = '0; last1 = '0;
    endtask

    task automatic send0(input int tag, input int from, input int to, input int restart,
                         input int eof_pos, input int bad_pos, input int bad_val);
        for (int p = from; p <= to; p++) begin
            int k, sq;
            logic sof, eof;
            k   = (restart >= 0 && p >= restart) ? p - restart : p;
            sof = (p == 0) || (p == restart);
            eof = (p == eof_pos);
            sq  = (p == bad_pos) ? bad_val : k;
            cycle(1'b1, {sl0(tag, k), sof, eof, 7'(sq)}, 1'b0, '0);
        end
    endtask

    task automatic send1(input int tag);
        for (int p = 0; p < NF1; p++) begin
            logic sof, eof;
            sof = (p == 0);
            eof = (p == NF1 - 1);
            cycle(1'b0, '0, 1'b1, {sl1(tag, p), sof, eof, 7'(p)});
        end
    endtask

    initial begin
        vecs[0] = '{"nominal",   19, -1, 18, -1, 0, 'h4A31, 1, 0, 0};
        vecs[1] = '{"seq_err",   19, -1, 18,  5, 7, 'h0002, 0, 1, 0};
        vecs[2] = '{"clean",     19, -1, 18, -1, 0, 'h7B05, 1, 0, 0};
        vecs[3] = '{"eof_early", 11, -1, 10, -1, 0, 'h0003, 0, 0, 1};
        vecs[4] = '{"no_eof",    19, -1, -1, -1, 0, 'h0004, 0, 0, 1};
        vecs[5] = '{"early_sof", 25,  6, 24, -1, 0, 'h6E19, 1, 1, 0};

        rst_n = 1'b0;
        rd_en0 = 0; rd_en1 = 0; data_in0 = '0; data_in1 = '0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        fq0 = '0;
        for (int i = 0; i < LAT1; i++) fq1[i] = '0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(valid0), '0);
        chk("rst_data", recv0, '0);
        chk("rst_done", DW'(done0), '0);
        chk("rst_errs", DW'({eseq0, elen0, eovf0}), '0);
        chk("rst_fcnt", DW'(fcnt0), '0);
        chk("rst_ready", DW'(decap_ready0), DW'(1));
        rst_n = 1'b1;
        idle(1);

        // Completion latency and single-cycle done pulse
        clr();
        send0('h1234, 0, 18, -1, 18, -1, 0);
        idle(1);
        chk("lat_done", DW'(done0), DW'(1));
        chk("lat_valid", DW'(valid0), DW'(1));
        idle(1);
        chk("lat_done_pulse", DW'(done0), '0);
        chk("lat_valid_clr", DW'(valid0), '0);
        chk("lat_data", last0, exp0('h1234));
        idle(2);

        for (int v = 0; v < 6; v++) begin
            clr();
            send0(vecs[v].tag, 0, vecs[v].n - 1, vecs[v].restart, vecs[v].eof_pos,
                  vecs[v].bad_pos, vecs[v].bad_val);
            idle(3);
            chk({vecs[v].name, "_done"}, DW'(cd0), DW'(vecs[v].e_done));
            chk({vecs[v].name, "_eseq"}, DW'(cs0), DW'(vecs[v].e_seq));
            chk({vecs[v].name, "_elen"}, DW'(cl0), DW'(vecs[v].e_len));
            chk({vecs[v].name, "_eovf"}, DW'(co0), '0);
            chk({vecs[v].name, "_fcnt"}, DW'(fcnt0), '0);
            chk({vecs[v].name, "_valid"}, DW'(valid0), '0);
            if (vecs[v].e_done != 0) chk({vecs[v].name, "_data"}, last0, exp0(vecs[v].tag));
        end

        // Backpressure: second completion dropped while first is held
        out_ready0 = 1'b0;
        clr();
        send0('h5A11, 0, 18, -1, 18, -1, 0);
        idle(2);
        send0('h3C22, 0, 18, -1, 18, -1, 0);
        idle(2);
        chk("bp_done", DW'(cd0), DW'(1));
        chk("bp_ovf", DW'(co0), DW'(1));
        chk("bp_valid", DW'(valid0), DW'(1));
        chk("bp_held", recv0, exp0('h5A11));
        send0('h2D33, 0, 17, -1, 18, -1, 0);
        idle(2);
        chk("bp_fcnt", DW'(fcnt0), DW'(18));
        chk("bp_notready", DW'(decap_ready0), '0);
        out_ready0 = 1'b1;
        #1;
        chk("bp_ready", DW'(decap_ready0), DW'(1));
        idle(1);
        chk("bp_valid_drop", DW'(valid0), '0);
        clr();
        send0('h2D33, 18, 18, -1, 18, -1, 0);
        idle(2);
        chk("bp_final_done", DW'(cd0), DW'(1));
        chk("bp_final_data", last0, exp0('h2D33));
        chk("bp_final_errs", DW'(cs0 + cl0 + co0), '0);

        // Reset mid-packet with a held output
        out_ready0 = 1'b0;
        send0('h1D44, 0, 18, -1, 18, -1, 0);
        idle(2);
        chk("mr_held", DW'(valid0), DW'(1));
        send0('h0E55, 0, 8, -1, 18, -1, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", DW'(valid0), '0);
        chk("mr_data", recv0, '0);
        chk("mr_fcnt", DW'(fcnt0), '0);
        chk("mr_ready", DW'(decap_ready0), DW'(1));
        chk("mr_pulses", DW'({done0, eseq0, elen0, eovf0}), '0);
        idle(3);
        rst_n = 1'b1;
        out_ready0 = 1'b1;
        clr();
        send0('h4F66, 0, 18, -1, 18, -1, 0);
        idle(2);
        chk("mr_after_done", DW'(cd0), DW'(1));
        chk("mr_after_data", last0, exp0('h4F66));

        // Wide frames, read latency 3
        clr();
        send1('h5B77);
        idle(LAT1);
        chk("w_done_lat", DW'(done1), DW'(1));
        idle(3);
        chk("w_done", DW'(cd1), DW'(1));
        chk("w_errs", DW'(cs1 + cl1 + co1), '0);
        chk("w_data", last1, exp1('h5B77));
        chk("w_valid", DW'(valid1), '0);
        chk("w_fcnt", DW'(fcnt1), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
